// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter: the frame state encoding and
// the line levels / bit counts that make up an 8N1 frame.
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic       START_BIT    = 1'b0;
    localparam logic       STOP_BIT     = 1'b1;
    localparam logic       IDLE_LINE    = 1'b1;
    localparam int         DATA_BITS    = 8;
    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Byte queue in front of the UART transmitter. Pushes are refused while full
// and pops are refused while empty, so the caller never corrupts the queue.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset (empties the queue)
//   i_push   write i_data this cycle (ignored while full)
//   i_data   byte to queue
//   i_pop    remove the head byte this cycle (ignored while empty)
//   o_data   head byte
//   o_level  occupancy, 0..DEPTH
//   o_full   o_level == DEPTH
//   o_empty  o_level == 0
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and level alone define validity.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
// Queued 8N1 UART transmitter. Bytes are pushed into a small FIFO and sent
// LSB first with one start and one stop bit; each bit lasts div_i+1 clocks,
// with div_i captured when the frame starts. Frames queued behind each other
// are sent with no idle gap.
//
// Ports
//   wb_clk_i  clock, rising edge
//   wb_rst_i  synchronous active-high reset; aborts any frame, empties queue
//   div_i     bit period minus one, in wb_clk_i cycles
//   data_i    byte to transmit
//   valid_i   data_i valid; accepted when ready_o is high
//   ready_o   queue can accept data_i
//   tx_o      registered serial line, idle high
//   busy_o    frame in progress or queue non-empty
//   level_o   queue occupancy
// ----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [DIV_WIDTH-1:0]          div_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    tx_state_t            r_state;
    logic                 r_tx;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [2:0]           r_idx;
    logic [7:0]           r_shift;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_cnt_done;
    logic [7:0]           w_head;

    assign ready_o    = ~w_full;
    assign w_push     = valid_i & ~w_full;
    assign w_cnt_done = (r_cnt == '0);
    assign tx_o       = r_tx;
    assign busy_o     = (r_state != ST_IDLE) | ~w_empty;

    // A frame starts either from IDLE as soon as a byte is queued, or straight
    // out of the last stop-bit cycle so that queued frames run back to back.
    assign w_pop = ~w_empty & ((r_state == ST_IDLE) |
                               ((r_state == ST_STOP) & w_cnt_done));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_push  (w_push),
        .i_data  (data_i),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (level_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_tx    <= IDLE_LINE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else if (w_pop) begin
            // Frame start: latch the byte and the divisor for the whole frame.
            r_state <= ST_START;
            r_tx    <= START_BIT;
            r_shift <= w_head;
            r_div   <= div_i;
            r_cnt   <= div_i;
            r_idx   <= '0;
        end else if (r_state != ST_IDLE) begin
            if (!w_cnt_done) begin
                r_cnt <= r_cnt - DIV_WIDTH'(1);
            end else begin
                r_cnt <= r_div;
                case (r_state)
                    ST_START: begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_idx   <= '0;
                    end
                    ST_DATA: begin
                        if (r_idx == LAST_BIT_IDX) begin
                            r_state <= ST_STOP;
                            r_tx    <= STOP_BIT;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end
                    ST_STOP: begin
                        // Queue was empty at stop-bit expiry (else w_pop won).
                        r_state <= ST_IDLE;
                        r_tx    <= IDLE_LINE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= IDLE_LINE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. Expected frames (byte + bit period) are
// queued when a byte is accepted and compared cycle by cycle against tx_o
// when the frame appears on the line.
// ----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int FIFO_DEPTH = 4;
    localparam int DIV_WIDTH  = 16;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic                 wb_clk_i = 1'b0;
    logic                 wb_rst_i;
    logic [DIV_WIDTH-1:0] div_i;
    logic [7:0]           data_i;
    logic                 valid_i;
    logic                 ready_o;
    logic                 tx_o;
    logic                 busy_o;
    logic [LW-1:0]        level_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    exp_t sb[$];        // frames expected on the line, in order
    exp_t tx_list[$];   // stimulus for drive_list
    int   acc_level[$]; // level_o seen one cycle after each accepted push
    int   acc_wait[$];  // cycles each push waited for ready_o

    always #5 wb_clk_i = ~wb_clk_i;

    uart_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .div_i    (div_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .tx_o     (tx_o),
        .busy_o   (busy_o),
        .level_o  (level_o)
    );

    // Push every entry of tx_list, holding valid_i until ready_o. Starts and ends on a negedge.
    task automatic drive_list(input int budget);
        acc_level.delete();
        acc_wait.delete();
        foreach (tx_list[i]) begin
            int waited;
            waited  = 0;
            valid_i = 1'b1;
            data_i  = tx_list[i].data;
            while (ready_o !== 1'b1 && waited < budget) begin
                @(negedge wb_clk_i);
                waited++;
            end
            if (ready_o !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL push_timeout byte %0d: ready_o=%b after %0d cycles, required 1", i, ready_o, waited);
                break;
            end
            sb.push_back(tx_list[i]);
            @(negedge wb_clk_i);
            acc_level.push_back(int'(level_o));
            acc_wait.push_back(waited);
        end
        valid_i = 1'b0;
    endtask

    // Receive n frames, each compared bit-cycle by bit-cycle against the scoreboard head.
    task automatic recv_frames(input int n, input bit no_gap, input int budget, output int first_gap);
        first_gap = -1;
        for (int f = 0; f < n; f++) begin
            int         gap;
            int         per;
            int         len;
            int         bad_bit;
            int         bad_busy;
            exp_t       e;
            logic [9:0] bits;
            logic [7:0] got;
            gap      = 0;
            bad_bit  = 0;
            bad_busy = 0;
            got      = '0;
            @(negedge wb_clk_i);
            while (tx_o !== 1'b0 && gap < budget) begin
                gap++;
                @(negedge wb_clk_i);
            end
            if (tx_o !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL start_timeout frame %0d: tx_o=%b for %0d cycles, required a start bit", f, tx_o, gap);
                return;
            end
            if (f == 0) first_gap = gap;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame %0d: a frame started, required none", f);
                return;
            end
            e    = sb.pop_front();
            per  = e.div + 1;
            len  = 10 * per;
            bits = {1'b1, e.data, 1'b0};
            for (int k = 0; k < len; k++) begin
                if (k > 0) @(negedge wb_clk_i);
                if (tx_o !== bits[k / per]) bad_bit++;
                if (busy_o !== 1'b1) bad_busy++;
                if ((k % per) == (per / 2) && (k / per) >= 1 && (k / per) <= 8)
                    got[(k / per) - 1] = tx_o;
            end
            checks++;
            if (bad_bit != 0) begin
                errors++;
                $display("FAIL frame_bits %0d (0x%02h, div %0d): %0d wrong bit cycles, required 0", f, e.data, e.div, bad_bit);
            end
            checks++;
            if (got !== e.data) begin
                errors++;
                $display("FAIL frame_byte %0d: got 0x%02h, required 0x%02h", f, got, e.data);
            end
            checks++;
            if (bad_busy != 0) begin
                errors++;
                $display("FAIL frame_busy %0d: busy_o low for %0d cycles, required 0", f, bad_busy);
            end
            if (no_gap && f > 0) begin
                checks++;
                if (gap != 0) begin
                    errors++;
                    $display("FAIL frame_gap %0d: %0d idle cycles, required 0", f, gap);
                end
            end
        end
    endtask

    // Watch ready_o/level_o consistency while the queue fills and drains.
    task automatic watch_ready(input int cycles);
        int bad;
        int over;
        bit saw_full;
        bad      = 0;
        over     = 0;
        saw_full = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge wb_clk_i);
            if (ready_o !== (level_o != FULL_LVL)) bad++;
            if (level_o > FULL_LVL) over++;
            if (level_o == FULL_LVL && ready_o === 1'b0) saw_full = 1'b1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ready_vs_level: %0d cycles with ready_o != (level_o != 4), required 0", bad);
        end
        checks++;
        if (over != 0) begin
            errors++;
            $display("FAIL level_overflow: %0d cycles above 4, required 0", over);
        end
        checks++;
        if (saw_full !== 1'b1) begin
            errors++;
            $display("FAIL saw_full: full with ready_o low seen=%b, required 1", saw_full);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_empty: %0d frames never sent, required 0", name, sb.size());
        end
        @(negedge wb_clk_i);
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== '0) begin
            errors++;
            $display("FAIL %s_idle: tx_o=%b busy_o=%b level_o=%0d, required 1 0 0", name, tx_o, busy_o, level_o);
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        valid_i  = 1'b1;
        data_i   = 8'h11;
        div_i    = 16'd3;
        repeat (3) @(negedge wb_clk_i);
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== '0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b level=%0d ready=%b, required 1 0 0 1", tx_o, busy_o, level_o, ready_o);
        end
        wb_rst_i = 1'b0;
        valid_i  = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        checks++;
        if (level_o !== '0 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: level=%0d tx=%b, required 0 1", level_o, tx_o);
        end
    endtask

    task automatic test_single();
        int g;
        div_i   = 16'd3;
        valid_i = 1'b1;
        data_i  = 8'hA5;
        sb.push_back('{8'hA5, 3});
        @(negedge wb_clk_i);
        valid_i = 1'b0;
        checks++;
        if (tx_o !== 1'b1 || level_o !== LW'(1) || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_after_push: tx=%b level=%0d busy=%b, required 1 1 1", tx_o, level_o, busy_o);
        end
        recv_frames(1, 1'b0, 8, g);
        checks++;
        if (g != 0) begin
            errors++;
            $display("FAIL single_latency: tx_o fell %0d cycles late, required 0", g);
        end
        check_drained("single");
    endtask

    task automatic test_back_to_back();
        int g;
        div_i = 16'd0;
        tx_list.delete();
        tx_list.push_back('{8'h00, 0});
        tx_list.push_back('{8'hFF, 0});
        tx_list.push_back('{8'h55, 0});
        fork
            drive_list(10);
            recv_frames(3, 1'b1, 20, g);
        join
        for (int i = 0; i < 3; i++) begin
            int want;
            want = (i == 2) ? 2 : 1;  // push+pop in the same cycle keeps the level
            checks++;
            if (acc_level.size() <= i || acc_level[i] != want) begin
                errors++;
                $display("FAIL b2b_level %0d: got %0d, required %0d", i, (acc_level.size() > i) ? acc_level[i] : -1, want);
            end
        end
        check_drained("b2b");
    endtask

    task automatic test_backpressure();
        int g;
        div_i = 16'd9;
        tx_list.delete();
        for (int i = 0; i < 7; i++) tx_list.push_back('{8'(8'h30 + i), 9});
        fork
            drive_list(400);
            recv_frames(7, 1'b1, 300, g);
            watch_ready(720);
        join
        checks++;
        if (acc_level.size() != 7 || acc_wait[4] != 0 || acc_level[4] != 4) begin
            errors++;
            $display("FAIL bp_fill: pushes=%0d, fifth byte wait/level not 0/4", acc_level.size());
        end
        for (int i = 5; i < 7; i++) begin
            checks++;
            if (acc_level.size() != 7 || acc_wait[i] == 0 || acc_level[i] != 4) begin
                errors++;
                $display("FAIL bp_late_push %0d: wait=%0d level=%0d, required wait>0 level 4", i,
                         (acc_wait.size() > i) ? acc_wait[i] : -1, (acc_level.size() > i) ? acc_level[i] : -1);
            end
        end
        check_drained("bp");
    endtask

    task automatic test_div_change();
        int g;
        div_i = 16'd3;
        tx_list.delete();
        tx_list.push_back('{8'h3C, 3});
        tx_list.push_back('{8'hC3, 7});
        fork
            drive_list(10);
            begin
                repeat (12) @(negedge wb_clk_i);
                div_i = 16'd7;
            end
            recv_frames(2, 1'b1, 20, g);
        join
        check_drained("divchg");
    endtask

    task automatic test_reset_mid_frame();
        int hi;
        div_i = 16'd3;
        tx_list.delete();
        tx_list.push_back('{8'hF7, 3});
        tx_list.push_back('{8'h12, 3});
        tx_list.push_back('{8'h34, 3});
        drive_list(10);
        // Now one cycle into the start bit; advance into data bit 3.
        repeat (16) @(negedge wb_clk_i);
        checks++;
        if (tx_o !== 1'b0 || level_o !== LW'(2)) begin
            errors++;
            $display("FAIL rst_pre: tx=%b level=%0d, required 0 2 (data bit 3 of 0xF7)", tx_o, level_o);
        end
        wb_rst_i = 1'b1;
        valid_i  = 1'b1;
        data_i   = 8'h99;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        valid_i  = 1'b0;
        checks++;
        if (tx_o !== 1'b1 || level_o !== '0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort: tx=%b level=%0d busy=%b ready=%b, required 1 0 0 1", tx_o, level_o, busy_o, ready_o);
        end
        sb.delete();
        hi = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge wb_clk_i);
            if (tx_o === 1'b1 && busy_o === 1'b0 && level_o === '0) hi++;
        end
        checks++;
        if (hi != 100) begin
            errors++;
            $display("FAIL rst_quiet: idle cycles %0d, required 100", hi);
        end
    endtask

    initial begin
        wb_rst_i = 1'b1;
        valid_i  = 1'b0;
        data_i   = '0;
        div_i    = '0;
        @(negedge wb_clk_i);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_div_change();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
